// File: rtl/lcd_text_pkg.sv
// lcd_text_pkg: display geometry, control codes and controller states for the LCD text buffer
package lcd_text_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 16;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;
    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL, BLANK} state_t;
endpackage

// File: rtl/lcd_text_ram.sv
// lcd_text_ram: 64x8 text store, one write port, registered LCD-side and scroll-side read ports
module lcd_text_ram
    import lcd_text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] ra_addr,
    output logic [7:0] ra_data,
    input  logic [5:0] rb_addr,
    output logic [7:0] rb_data
);
    logic [7:0] mem [ROWS*COLS];
    // storage is deliberately unreset; the controller clears it after reset
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    // both read ports return the contents before any same-edge write
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ra_data <= 8'h00;
            rb_data <= 8'h00;
        end else begin
            ra_data <= mem[ra_addr];
            rb_data <= mem[rb_addr];
        end
endmodule

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 4x16 character buffer with cursor, control codes and per-row dirty flags; LCD_TEXT_SCROLL_EN selects scroll instead of wrap-to-top
module lcd_text_buffer
    import lcd_text_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR           = 8'h20,
    parameter int         SCROLL_CYC_PER_BYTE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ch_valid,
    input  logic [7:0] ch_data,
    output logic       ch_ready,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [3:0] dirty,
    input  logic [3:0] dirty_clr,
    output logic       busy,
    output logic [1:0] cur_row,
    output logic [3:0] cur_col
);
`ifdef LCD_TEXT_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif
    localparam int PW = SCROLL_CYC_PER_BYTE > 1 ? $clog2(SCROLL_CYC_PER_BYTE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(SCROLL_CYC_PER_BYTE - 1);

    state_t        state, state_n;
    logic [5:0]    cnt, cnt_n, waddr, rb_addr;
    logic [PW-1:0] phase, phase_n;
    logic [1:0]    row, row_n, blank_row, blank_row_n;
    logic [3:0]    col, col_n, dirty_set;
    logic [7:0]    wdata, rb_data;
    logic          we, hs, printable;

    assign ch_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign hs        = ch_valid && ch_ready;
    assign printable = ch_data >= 8'h20 && ch_data <= 8'h7E;
    assign cur_row   = row;
    assign cur_col   = col;
    assign rb_addr   = cnt + 6'd16;

    lcd_text_ram u_ram (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(rd_addr), .ra_data(rd_data), .rb_addr(rb_addr), .rb_data(rb_data)
    );

    // next state, cursor, store write and dirty-set decode; scroll reads source at phase 0, writes at last phase
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 6'd1;
        phase_n     = phase;
        row_n       = row;
        col_n       = col;
        blank_row_n = blank_row;
        dirty_set   = 4'h0;
        we          = 1'b0;
        waddr       = cnt;
        wdata       = FILL_CHAR;
        case (state)
            CLEAR: begin
                we = 1'b1;
                if (cnt == 6'd63) begin
                    state_n   = IDLE;
                    dirty_set = 4'hF;
                end
            end
            BLANK: begin
                we    = 1'b1;
                waddr = {blank_row, cnt[3:0]};
                if (cnt == 6'd15) begin
                    state_n   = IDLE;
                    dirty_set = SCROLL_EN ? 4'hF : 4'h1 << blank_row;
                end
            end
            SCROLL: begin
                we      = phase == PH_LAST;
                wdata   = rb_data;
                phase_n = we ? '0 : phase + 1'b1;
                cnt_n   = we ? cnt + 6'd1 : cnt;
                if (we && cnt == 6'd47) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                end
            end
            default: begin
                cnt_n   = '0;
                phase_n = '0;
                waddr   = {row, col};
                if (hs && printable) begin
                    we             = 1'b1;
                    wdata          = ch_data;
                    dirty_set[row] = 1'b1;
                    col_n          = col + 4'd1;
                end
                if (hs && ch_data == BS && col != 4'd0) begin
                    we             = 1'b1;
                    waddr          = {row, col - 4'd1};
                    dirty_set[row] = 1'b1;
                    col_n          = col - 4'd1;
                end
                if (hs && ch_data == CR) col_n = 4'd0;
                if (hs && ch_data == FF) begin
                    row_n     = 2'd0;
                    col_n     = 4'd0;
                    dirty_set = 4'hF;
                    state_n   = CLEAR;
                end
                if (hs && (ch_data == LF || (printable && col == 4'd15))) begin
                    col_n = 4'd0;
                    if (row != 2'd3) row_n = row + 2'd1;
                    else if (SCROLL_EN) begin
                        state_n     = SCROLL;
                        blank_row_n = 2'd3;
                    end else begin
                        state_n     = BLANK;
                        row_n       = 2'd0;
                        blank_row_n = 2'd0;
                    end
                end
            end
        endcase
    end

    // state registers; dirty set wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            phase     <= '0;
            row       <= '0;
            col       <= '0;
            blank_row <= '0;
            dirty     <= 4'hF;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            row       <= row_n;
            col       <= col_n;
            blank_row <= blank_row_n;
            dirty     <= (dirty & ~dirty_clr) | dirty_set;
        end
endmodule

// File: doc/lcd_text_buffer.md
LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 SHALL have parameter: FILL_CHAR, 8'h20, byte written by clear, blank and backspace operations.
REQ-002 SHALL have parameter: SCROLL_CYC_PER_BYTE, 2, cycles per copied byte during scroll (read, then write).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: ch_valid  in  1  upstream character valid.
REQ-006 SHALL have port: ch_data  in  8  ASCII character or control code.
REQ-007 SHALL have port: ch_ready  out  1  block accepts ch_data this cycle.
REQ-008 SHALL have port: rd_addr  in  6  LCD-side read address, row*16+col.
REQ-009 SHALL have port: rd_data  out  8  registered read data.
REQ-010 SHALL have port: dirty  out  4  per-row "changed since last refresh" flags.
REQ-011 SHALL have port: dirty_clr  in  4  per-row clear strobes from the LCD writer.
REQ-012 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port: cur_row  out  2  and cur_col  out  4, the cursor position.

Function
REQ-014 SHALL hold a 64x8 text store; address = row*16+col; row order 0..3 equals display lines 0x80/0x90/0x88/0x98.
REQ-015 SHALL implement states CLEAR, IDLE, SCROLL, BLANK; ch_ready = 1 only in IDLE.
REQ-016 CLEAR SHALL write FILL_CHAR to addresses 0..63, one per cycle, 64 cycles, then enter IDLE.
REQ-017 A handshake SHALL occur on ch_valid & ch_ready; exactly one character consumed per handshake.
REQ-018 Printable 0x20-0x7E SHALL be written at cursor in the handshake cycle, set dirty[cur_row], and increment cur_col.
REQ-019 A printable at col 15 SHALL be followed by a row advance (col 0, next row).
REQ-020 0x0D SHALL set col 0; 0x0A SHALL perform a row advance; 0x0C SHALL set cursor (0,0), dirty 4'hF, and enter CLEAR.
REQ-021 0x08 at col>0 SHALL decrement col and write FILL_CHAR there (dirty set); at col 0 it SHALL be a no-op.
REQ-022 All other codes SHALL be consumed and discarded without any state change.
REQ-023 A row advance from row<3 SHALL increment row with no busy period.
REQ-024 A row advance from row 3 SHALL follow the scroll option (REQ-031/032).
REQ-025 BLANK SHALL write FILL_CHAR to the 16 addresses of the target row over 16 cycles, then enter IDLE.
REQ-026 rd_data SHALL equal store[rd_addr] sampled one cycle earlier (1-cycle latency); the read port is independent of state.
REQ-027 Dirty bits SHALL be set only when the operation that changed the row completes.
REQ-028 Same-cycle dirty set and dirty_clr on one row SHALL leave the bit set.

Reset
REQ-029 Asserting rst_n low SHALL set state CLEAR, cursor (0,0), dirty 4'hF, ch_ready 0, busy 1, rd_data 8'h00.
REQ-030 Reset mid-operation SHALL abort SCROLL/BLANK/CLEAR; after release a full 64-cycle CLEAR SHALL run; the store itself has no reset.

Configuration
REQ-031 With LCD_TEXT_SCROLL_EN defined, row-3 advance SHALL enter SCROLL (copy 16..63 to 0..47, 48*SCROLL_CYC_PER_BYTE cycles), then BLANK row 3; cursor (3,0); dirty 4'hF.
REQ-032 Without LCD_TEXT_SCROLL_EN, row-3 advance SHALL set cursor (0,0) and BLANK row 0; dirty[0] set; rows 1-3 unchanged.

Structure
REQ-033 Package lcd_text_pkg SHALL hold ROWS=4, COLS=16, control-code constants (CR, LF, BS, FF), and the state enum.
REQ-034 Storage SHALL be sub-module lcd_text_ram: one write port, two registered read ports (LCD side, scroll side).

Verification
REQ-035 Release reset -> busy high exactly 64 cycles; all 64 reads = 8'h20; dirty = 4'hF; cursor (0,0).
REQ-036 dirty_clr 4'hF, send "HELLO" -> addr 0..4 = 48 45 4C 4C 4F; cur_col 5; dirty = 4'b0001.
REQ-037 Send 17 printables from (0,0) -> cursor after 16th is (1,0); 17th stored at addr 16.
REQ-038 Cursor (3,5), send 0x0A -> with macro: row0 = old row1, row3 all 8'h20, cursor (3,0), dirty 4'hF; without: row0 blank, cursor (0,0).
REQ-039 0x08 at col 0 -> no change; at col 3 -> col 2, addr (row*16+2) = 8'h20.
REQ-040 ch_valid held high during busy -> ch_ready 0, no loss; same-cycle write and dirty_clr on row 0 -> dirty[0] remains 1.
